reg_bank_arbiter: RTL and testbench
===================================

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_CFG, default 8, number of config registers.
REQ-002 SHALL have parameter NUM_STATUS, default 8, number of status registers; must equal NUM_CFG.
REQ-003 SHALL have parameter REG_WIDTH, default 8, bits per register.
REQ-004 SHALL have parameter RR_EN, default 1: 1 = round-robin on contention, 0 = fixed priority by sel.
REQ-005 SHALL have one clock and a synchronous active-high reset; all state changes on rising clk.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-008 SHALL have port ena, input, 1, 0 freezes FSM and registers.
REQ-009 SHALL have port sel, input, 1, priority winner when RR_EN=0 (0 = SPI, 1 = I2C).
REQ-010 SHALL have per requester p in {spi, i2c}: p_req in 1, p_we in 1, p_addr in 4, p_wdata in REG_WIDTH.
REQ-011 SHALL have per requester p: p_ack out 1, p_err out 1, p_rdata out REG_WIDTH.
REQ-012 SHALL have port status_regs, input, NUM_STATUS*REG_WIDTH, read-only status image.
REQ-013 SHALL have port config_regs, output, NUM_CFG*REG_WIDTH, config register image, register i at bits [i*REG_WIDTH +: REG_WIDTH].
REQ-014 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, ACK.
REQ-016 IDLE, no request: stay in IDLE.
REQ-017 IDLE, any req high: latch owner, we, addr, wdata; go to ACCESS next cycle.
REQ-018 Single requester SHALL always win.
REQ-019 Contention, RR_EN=1: grant the requester not served last; last_owner resets to I2C, so SPI wins the first contention.
REQ-020 Contention, RR_EN=0: grant SPI if sel=0, I2C if sel=1.
REQ-021 ACCESS, address decode: addr[3]=0 selects config[addr[2:0]]; addr[3]=1 selects status[addr[2:0]].
REQ-022 ACCESS, write to config: update the register at the end of the cycle; rdata = new value.
REQ-023 ACCESS, read: rdata registered from the addressed config or status register.
REQ-024 ACCESS, write to status space: no write; err=1; rdata = current status value.
REQ-025 ACCESS, index >= NUM_CFG (when NUM_CFG < 8): no write; rdata = 0; err=1.
REQ-026 ACCESS SHALL always go to ACK next cycle.
REQ-027 ACK: owner's p_ack=1 for exactly one cycle, with p_rdata and p_err valid; then IDLE.
REQ-028 Latency: req sampled in IDLE at cycle N gives ack at cycle N+2; next grant earliest N+3.
REQ-029 The req input SHALL be ignored in ACCESS and ACK; no preemption; a requester holds we/addr/wdata stable until ack and drops req on the cycle after ack, else a new access follows.
REQ-030 The loser's req SHALL stay pending and be granted in the next IDLE cycle.
REQ-031 Non-owner p_ack and p_err SHALL be 0; p_rdata holds its last value.
REQ-032 ena=0 SHALL hold state, latches, config and outputs; a pending ack stays asserted until ena returns and the ACK cycle completes.
REQ-033 Simultaneous req rise: resolved per REQ-019 and REQ-020 in the same IDLE cycle.

Reset
REQ-034 rst=1 SHALL force IDLE, config_regs = 0, all acks and errs = 0, all rdata = 0, busy = 0, last_owner = I2C.
REQ-035 rst SHALL take priority over ena.
REQ-036 rst mid-transaction SHALL abort: no write, no ack.

Structure
REQ-037 Package reg_bank_pkg SHALL hold: the state enum (IDLE/ACCESS/ACK), the owner enum (OWN_SPI/OWN_I2C), ADDR_WIDTH=4, and the STATUS_SPACE bit index 3.
REQ-038 Sub-module reg_bank_regfile SHALL hold the config storage, write port and read mux; the arbiter FSM instantiates it once.

Verification
REQ-039 Write: SPI writes 0xA5 to addr 0x2 -> spi_ack at N+2, spi_err=0, spi_rdata=0xA5, config_regs[23:16]=0xA5.
REQ-040 Status read: I2C reads addr 0xB with status byte 3 = 0x55 -> i2c_rdata=0x55, i2c_err=0, config unchanged.
REQ-041 Status write: SPI writes 0x12 to addr 0x8 -> spi_err=1, spi_rdata = status byte 0 (0xCA), config unchanged.
REQ-042 Contention, RR_EN=1: both req held for 4 accesses -> grants SPI, I2C, SPI, I2C, 3 cycles apart.
REQ-043 Contention, RR_EN=0, sel=1: both req -> I2C served first, SPI second.
REQ-044 Reset mid-access: rst asserted in ACCESS of a write of 0xFF to addr 0 -> config_regs[7:0]=0, no ack, busy=0 next cycle.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register bank arbiter.
// Holds the FSM and owner encodings plus address layout.
package reg_bank_pkg;

    localparam int ADDR_WIDTH   = 4;
    localparam int STATUS_SPACE = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    typedef enum logic {
        OWN_SPI = 1'b0,
        OWN_I2C = 1'b1
    } owner_e;

endpackage

// File: rtl/reg_bank_regfile.sv
// Config register storage, single write port and config/status read mux.
// Out-of-range indices read as zero and flag an error.
module reg_bank_regfile
    import reg_bank_pkg::*;
#(
    parameter int NUM_CFG   = 8,
    parameter int REG_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [REG_WIDTH-1:0]           wdata,
    input  logic [NUM_CFG*REG_WIDTH-1:0]   status_regs,
    output logic [NUM_CFG*REG_WIDTH-1:0]   config_regs,
    output logic [REG_WIDTH-1:0]           rd_data,
    output logic                           rd_err
);

    logic [REG_WIDTH-1:0]    cfg_q [NUM_CFG];
    logic [REG_WIDTH-1:0]    cfg_d [NUM_CFG];
    logic [STATUS_SPACE-1:0] idx;
    logic                    status_sp;
    logic                    hit;
    logic [REG_WIDTH-1:0]    cfg_sel;
    logic [REG_WIDTH-1:0]    st_sel;

    assign idx       = addr[STATUS_SPACE-1:0];
    assign status_sp = addr[STATUS_SPACE];

    // Select the addressed config and status entries; flag in-range hits.
    always_comb begin
        hit     = 1'b0;
        cfg_sel = '0;
        st_sel  = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (int'(idx) == i) begin
                hit     = 1'b1;
                cfg_sel = cfg_q[i];
                st_sel  = status_regs[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Read result: writes to config echo the new value.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if (hit) begin
            if (status_sp) begin
                rd_data = st_sel;
                rd_err  = we;
            end else begin
                rd_data = we ? wdata : cfg_sel;
                rd_err  = 1'b0;
            end
        end
    end

    // Next config contents: only in-range config-space writes land.
    always_comb begin
        cfg_d = cfg_q;
        if (wr_en && we && hit && !status_sp) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (int'(idx) == i) begin
                    cfg_d[i] = wdata;
                end
            end
        end
    end

    // Config storage with synchronous clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rst) begin
                cfg_q[i] <= '0;
            end else begin
                cfg_q[i] <= cfg_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_img
        assign config_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_q[g];
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-master (SPI/I2C) arbiter in front of a config/status register bank.
// Each grant runs IDLE -> ACCESS -> ACK, acking the owner two cycles later.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8,
    parameter int RR_EN      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic                            sel,
    input  logic                            spi_req,
    input  logic                            spi_we,
    input  logic [ADDR_WIDTH-1:0]           spi_addr,
    input  logic [REG_WIDTH-1:0]            spi_wdata,
    output logic                            spi_ack,
    output logic                            spi_err,
    output logic [REG_WIDTH-1:0]            spi_rdata,
    input  logic                            i2c_req,
    input  logic                            i2c_we,
    input  logic [ADDR_WIDTH-1:0]           i2c_addr,
    input  logic [REG_WIDTH-1:0]            i2c_wdata,
    output logic                            i2c_ack,
    output logic                            i2c_err,
    output logic [REG_WIDTH-1:0]            i2c_rdata,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    output logic                            busy
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_q, last_d;
    owner_e                grant;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [REG_WIDTH-1:0]  spi_rdata_q, spi_rdata_d;
    logic [REG_WIDTH-1:0]  i2c_rdata_q, i2c_rdata_d;
    logic                  rf_wr_en;
    logic [REG_WIDTH-1:0]  rf_rdata;
    logic                  rf_err;

    assign rf_wr_en = ena && (state_q == ACCESS);

    reg_bank_regfile #(
        .NUM_CFG   (NUM_CFG),
        .REG_WIDTH (REG_WIDTH)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (rf_wr_en),
        .we          (we_q),
        .addr        (addr_q),
        .wdata       (wdata_q),
        .status_regs (status_regs),
        .config_regs (config_regs),
        .rd_data     (rf_rdata),
        .rd_err      (rf_err)
    );

    // Pick the winner: lone requester, else round-robin or sel priority.
    always_comb begin
        grant = OWN_SPI;
        if (spi_req && i2c_req) begin
            if (RR_EN != 0) begin
                if (last_q == OWN_SPI) grant = OWN_I2C;
                else                   grant = OWN_SPI;
            end else if (sel) begin
                grant = OWN_I2C;
            end
        end else if (!spi_req) begin
            grant = OWN_I2C;
        end
    end

    // FSM and transaction latches; ena low freezes everything.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        spi_rdata_d = spi_rdata_q;
        i2c_rdata_d = i2c_rdata_q;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (spi_req || i2c_req) begin
                        owner_d = grant;
                        last_d  = grant;
                        if (grant == OWN_SPI) begin
                            we_d    = spi_we;
                            addr_d  = spi_addr;
                            wdata_d = spi_wdata;
                        end else begin
                            we_d    = i2c_we;
                            addr_d  = i2c_addr;
                            wdata_d = i2c_wdata;
                        end
                        state_d = ACCESS;
                    end
                end
                ACCESS: begin
                    err_d = rf_err;
                    if (owner_q == OWN_SPI) spi_rdata_d = rf_rdata;
                    else                    i2c_rdata_d = rf_rdata;
                    state_d = ACK;
                end
                ACK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_SPI;
            last_q      <= OWN_I2C;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            spi_rdata_q <= '0;
            i2c_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            spi_rdata_q <= spi_rdata_d;
            i2c_rdata_q <= i2c_rdata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign spi_ack   = (state_q == ACK) && (owner_q == OWN_SPI);
    assign i2c_ack   = (state_q == ACK) && (owner_q == OWN_I2C);
    assign spi_err   = spi_ack && err_q;
    assign i2c_err   = i2c_ack && err_q;
    assign spi_rdata = spi_rdata_q;
    assign i2c_rdata = i2c_rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: two instances (RR 8 regs, fixed-priority 6 regs)
// checked every cycle against a transaction-level model plus literal checks.
module tb_reg_bank_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ena, sel;
    logic        spi_req, spi_we, i2c_req, i2c_we;
    logic [3:0]  spi_addr, i2c_addr;
    logic [7:0]  spi_wdata, i2c_wdata;
    logic [63:0] status;

    logic        spi_ack_o [2];
    logic        spi_err_o [2];
    logic        i2c_ack_o [2];
    logic        i2c_err_o [2];
    logic        busy_o    [2];
    logic [7:0]  spi_rd_o  [2];
    logic [7:0]  i2c_rd_o  [2];
    logic [63:0] cfg0;
    logic [47:0] cfg1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    reg_bank_arbiter #(
        .NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8), .RR_EN(1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .ena(ena), .sel(sel),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr),
        .spi_wdata(spi_wdata), .spi_ack(spi_ack_o[0]),
        .spi_err(spi_err_o[0]), .spi_rdata(spi_rd_o[0]),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr),
        .i2c_wdata(i2c_wdata), .i2c_ack(i2c_ack_o[0]),
        .i2c_err(i2c_err_o[0]), .i2c_rdata(i2c_rd_o[0]),
        .status_regs(status), .config_regs(cfg0), .busy(busy_o[0])
    );

    reg_bank_arbiter #(
        .NUM_CFG(6), .NUM_STATUS(6), .REG_WIDTH(8), .RR_EN(0)
    ) u_dut1 (
        .clk(clk), .rst(rst), .ena(ena), .sel(sel),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr),
        .spi_wdata(spi_wdata), .spi_ack(spi_ack_o[1]),
        .spi_err(spi_err_o[1]), .spi_rdata(spi_rd_o[1]),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr),
        .i2c_wdata(i2c_wdata), .i2c_ack(i2c_ack_o[1]),
        .i2c_err(i2c_err_o[1]), .i2c_rdata(i2c_rd_o[1]),
        .status_regs(status[47:0]), .config_regs(cfg1), .busy(busy_o[1])
    );

    // model: m_ph = cycles since grant (0 idle, 1 access, 2 ack)
    int         m_ph   [2];
    int         m_own  [2];
    int         m_last [2];
    bit         m_we   [2];
    logic [3:0] m_addr [2];
    logic [7:0] m_wd   [2];
    bit         m_err  [2];
    logic [7:0] m_srd  [2];
    logic [7:0] m_ird  [2];
    logic [7:0] m_cfg  [2][8];

    function automatic int ncfg(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    task automatic cmp(input string nm, input int k,
                       input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h t=%0t",
                     nm, k, act, want, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // model update on each rising edge, from the transaction rules
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ph[k] = 0; m_last[k] = 1; m_own[k] = 0;
                m_err[k] = 0; m_srd[k] = 8'h00; m_ird[k] = 8'h00;
                for (int i = 0; i < 8; i++) m_cfg[k][i] = 8'h00;
            end else if (ena) begin
                if (m_ph[k] == 0) begin
                    if (spi_req || i2c_req) begin
                        int w;
                        if (spi_req && i2c_req)
                            w = (k == 0) ? 1 - m_last[k] : (sel ? 1 : 0);
                        else
                            w = spi_req ? 0 : 1;
                        m_own[k] = w; m_last[k] = w;
                        m_we[k]   = w ? i2c_we : spi_we;
                        m_addr[k] = w ? i2c_addr : spi_addr;
                        m_wd[k]   = w ? i2c_wdata : spi_wdata;
                        m_ph[k] = 1;
                    end
                end else if (m_ph[k] == 1) begin
                    int idx;
                    logic [7:0] rd;
                    bit e;
                    idx = int'(m_addr[k][2:0]);
                    if (idx >= ncfg(k)) begin
                        rd = 8'h00; e = 1;
                    end else if (m_addr[k][3]) begin
                        rd = status[idx*8 +: 8]; e = m_we[k];
                    end else if (m_we[k]) begin
                        m_cfg[k][idx] = m_wd[k]; rd = m_wd[k]; e = 0;
                    end else begin
                        rd = m_cfg[k][idx]; e = 0;
                    end
                    m_err[k] = e;
                    if (m_own[k] == 0) m_srd[k] = rd;
                    else               m_ird[k] = rd;
                    m_ph[k] = 2;
                end else begin
                    m_ph[k] = 0;
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [63:0] wc, ac;
                bit sa, ia;
                wc = '0;
                for (int i = 0; i < ncfg(k); i++) wc[i*8 +: 8] = m_cfg[k][i];
                ac = (k == 0) ? cfg0 : {16'h0, cfg1};
                sa = (m_ph[k] == 2) && (m_own[k] == 0);
                ia = (m_ph[k] == 2) && (m_own[k] == 1);
                cmp("m_busy",    k, busy_o[k],    m_ph[k] != 0);
                cmp("m_spi_ack", k, spi_ack_o[k], sa);
                cmp("m_i2c_ack", k, i2c_ack_o[k], ia);
                cmp("m_spi_err", k, spi_err_o[k], sa && m_err[k]);
                cmp("m_i2c_err", k, i2c_err_o[k], ia && m_err[k]);
                cmp("m_spi_rd",  k, spi_rd_o[k],  m_srd[k]);
                cmp("m_i2c_rd",  k, i2c_rd_o[k],  m_ird[k]);
                cmp("m_cfg",     k, ac,           wc);
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; sel = 1'b0;
        spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
        i2c_req = 0; i2c_we = 0; i2c_addr = 0; i2c_wdata = 0;
        status = 64'h1122_3344_5566_77CA;
        tick; tick;
        chk_en = 1'b1;
        cmp("rst_busy", 0, busy_o[0], 1'b0);
        cmp("rst_cfg", 0, cfg0, 64'h0);
        cmp("rst_ack", 0, spi_ack_o[0], 1'b0);
        rst = 1'b0;

        // SPI writes A5 to config 2
        spi_req = 1; spi_we = 1; spi_addr = 4'h2; spi_wdata = 8'hA5;
        tick; spi_req = 0;
        cmp("wr_busy", 0, busy_o[0], 1'b1);
        cmp("wr_early_ack", 0, spi_ack_o[0], 1'b0);
        tick;
        cmp("wr_ack", 0, spi_ack_o[0], 1'b1);
        cmp("wr_err", 0, spi_err_o[0], 1'b0);
        cmp("wr_rdata", 0, spi_rd_o[0], 8'hA5);
        cmp("wr_cfg", 0, cfg0[23:16], 8'hA5);
        tick;
        cmp("wr_ack_drop", 0, spi_ack_o[0], 1'b0);
        cmp("wr_idle", 0, busy_o[0], 1'b0);

        // I2C reads status 3
        i2c_req = 1; i2c_we = 0; i2c_addr = 4'hB;
        tick; i2c_req = 0;
        tick;
        cmp("st_rd_ack", 0, i2c_ack_o[0], 1'b1);
        cmp("st_rd_data", 0, i2c_rd_o[0], 8'h55);
        cmp("st_rd_err", 0, i2c_err_o[0], 1'b0);
        cmp("st_rd_cfg", 0, cfg0, 64'h0000_0000_00A5_0000);
        tick;

        // SPI writes into status space
        spi_req = 1; spi_we = 1; spi_addr = 4'h8; spi_wdata = 8'h12;
        tick; spi_req = 0;
        tick;
        cmp("st_wr_err", 0, spi_err_o[0], 1'b1);
        cmp("st_wr_rdata", 0, spi_rd_o[0], 8'hCA);
        cmp("st_wr_cfg", 0, cfg0, 64'h0000_0000_00A5_0000);
        tick;

        // index 6: out of range only for the 6-register instance
        spi_req = 1; spi_we = 1; spi_addr = 4'h6; spi_wdata = 8'h3C;
        tick; spi_req = 0;
        tick;
        cmp("oor_err", 1, spi_err_o[1], 1'b1);
        cmp("oor_rdata", 1, spi_rd_o[1], 8'h00);
        cmp("oor_cfg", 1, cfg1, 48'h0000_00A5_0000);
        cmp("inr_err", 0, spi_err_o[0], 1'b0);
        cmp("inr_rdata", 0, spi_rd_o[0], 8'h3C);
        tick;

        // ena low during ACK holds the ack
        spi_req = 1; spi_we = 0; spi_addr = 4'h2;
        tick; spi_req = 0;
        tick; ena = 0;
        tick; tick;
        cmp("hold_ack", 0, spi_ack_o[0], 1'b1);
        cmp("hold_rdata", 0, spi_rd_o[0], 8'hA5);
        ena = 1;
        tick;
        cmp("hold_release", 0, spi_ack_o[0], 1'b0);

        // round-robin contention, four accesses
        do_reset;
        spi_req = 1; i2c_req = 1; spi_we = 0; i2c_we = 0;
        spi_addr = 4'h1; i2c_addr = 4'h9; sel = 0;
        for (int a = 0; a < 4; a++) begin
            tick; tick;
            cmp("rr_spi", 0, spi_ack_o[0], (a % 2) == 0);
            cmp("rr_i2c", 0, i2c_ack_o[0], (a % 2) == 1);
            tick;
        end
        spi_req = 0; i2c_req = 0;
        tick; tick; tick;

        // fixed priority, sel=1
        do_reset;
        sel = 1; spi_req = 1; i2c_req = 1;
        tick; tick;
        cmp("fp_i2c_first", 1, i2c_ack_o[1], 1'b1);
        cmp("fp_spi_wait", 1, spi_ack_o[1], 1'b0);
        i2c_req = 0;
        tick; tick; tick;
        cmp("fp_spi_second", 1, spi_ack_o[1], 1'b1);
        spi_req = 0; sel = 0;
        tick;

        // reset during ACCESS of a write aborts it
        do_reset;
        spi_req = 1; spi_we = 1; spi_addr = 4'h0; spi_wdata = 8'hFF;
        tick; spi_req = 0; rst = 1;
        tick;
        cmp("abort_cfg", 0, cfg0[7:0], 8'h00);
        cmp("abort_busy", 0, busy_o[0], 1'b0);
        cmp("abort_ack", 0, spi_ack_o[0], 1'b0);
        rst = 0;
        tick;
        cmp("abort_no_ack", 0, spi_ack_o[0], 1'b0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            ena       = ($urandom_range(0, 7) != 0);
            sel       = $urandom_range(0, 1);
            spi_req   = $urandom_range(0, 1);
            i2c_req   = $urandom_range(0, 1);
            spi_we    = $urandom_range(0, 1);
            i2c_we    = $urandom_range(0, 1);
            spi_addr  = 4'($urandom);
            i2c_addr  = 4'($urandom);
            spi_wdata = 8'($urandom);
            i2c_wdata = 8'($urandom);
            if ($urandom_range(0, 15) == 0)
                status = {32'($urandom), 32'($urandom)};
            tick;
        end
        rst = 0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
